// File: rtl/fetch_sequencer_pkg.sv
// Shared ISA definitions for the fetch sequencer and execute stage:
// opcodes, instruction field layout and sequencer state encoding.
package fetch_sequencer_pkg;

   localparam logic [5:0] OP_NOP  = 6'h00;
   localparam logic [5:0] OP_JMP  = 6'h01;
   localparam logic [5:0] OP_BZ   = 6'h02;
   localparam logic [5:0] OP_CALL = 6'h03;
   localparam logic [5:0] OP_RET  = 6'h04;
   localparam logic [5:0] OP_MUL  = 6'h10;
   localparam logic [5:0] OP_HALT = 6'h3F;

   typedef struct packed {
      logic [5:0]  opcode;
      logic [4:0]  rd;
      logic [4:0]  rs1;
      logic [15:0] imm;
   } ins_t;

   typedef enum logic [1:0] {
      ST_RUN  = 2'd0,
      ST_HOLD = 2'd1,
      ST_HALT = 2'd2
   } state_t;

endpackage

// File: rtl/fetch_sequencer_ras.sv
// Circular return-address stack; a push when full overwrites the oldest.
// Ports: clk, reset (async active-low), push, pop, din, top, empty, full.
module ret_addr_stack #(
   parameter int DEPTH = 4,
   parameter int W     = 16
) (
   input  logic         clk,
   input  logic         reset,
   input  logic         push,
   input  logic         pop,
   input  logic [W-1:0] din,
   output logic [W-1:0] top,
   output logic         empty,
   output logic         full
);

   localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

   logic [W-1:0]  mem [DEPTH];
   logic [AW-1:0] sp;
   logic [AW-1:0] sp_m1;
   logic [AW:0]   count;

   // sp points at the next free slot; wraps naturally for power-of-2 depth
   assign sp_m1 = sp - AW'(1);
   assign top   = mem[sp_m1];
   assign empty = (count == '0);
   assign full  = (count == (AW+1)'(DEPTH));

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         sp    <= '0;
         count <= '0;
         for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
      end else if (push) begin
         mem[sp] <= din;
         sp      <= sp + AW'(1);
         if (!full) count <= count + 1'b1;
      end else if (pop && !empty) begin
         sp    <= sp_m1;
         count <= count - 1'b1;
      end
   end

endmodule

// File: rtl/fetch_sequencer.sv
// Fetch sequencer: decodes control flow from program_memory, drives jumps
// and fetch stalls, and issues one registered decoded instruction per cycle.
// Ports: clk, reset (async active-low), ins, current_address, zero_flag in;
//   jmp_loc, pc_mux_sel (comb), stall, stall_pm, dec_* , halted, ras_err out.
module fetch_sequencer
   import fetch_sequencer_pkg::*;
#(
   parameter int MUL_CYCLES = 4,
   parameter int RAS_DEPTH  = 4
) (
   input  logic        clk,
   input  logic        reset,
   input  logic [31:0] ins,
   input  logic [15:0] current_address,
   input  logic        zero_flag,
   output logic [15:0] jmp_loc,
   output logic        pc_mux_sel,
   output logic        stall,
   output logic        stall_pm,
   output logic        dec_valid,
   output logic [5:0]  dec_opcode,
   output logic [4:0]  dec_rd,
   output logic [4:0]  dec_rs1,
   output logic [15:0] dec_imm,
   output logic [15:0] dec_pc,
   output logic        halted,
   output logic        ras_err
);

   localparam int CW = $clog2(MUL_CYCLES) + 1;
   localparam logic [CW-1:0] CNT_INIT =
      (MUL_CYCLES > 1) ? CW'(MUL_CYCLES - 2) : '0;

   ins_t          f;
   state_t        state, state_d;
   logic [CW-1:0] cnt, cnt_d;
   logic          stall_d;
   logic [15:0]   ins_pc;
   logic          push, pop, err_set, halt_set;
   logic [15:0]   ras_top;
   logic          ras_empty, ras_full;

   assign f = ins_t'(ins);

   ret_addr_stack #(.DEPTH(RAS_DEPTH), .W(16)) u_ras (
      .clk   (clk),
      .reset (reset),
      .push  (push),
      .pop   (pop),
      .din   (ins_pc + 16'd1),
      .top   (ras_top),
      .empty (ras_empty),
      .full  (ras_full)
   );

   // Control decode only acts in RUN, so ins replayed during a stall
   // never feeds back into pc_mux_sel.
   always_comb begin
      state_d    = state;
      cnt_d      = cnt;
      stall_d    = stall;
      pc_mux_sel = 1'b0;
      jmp_loc    = '0;
      push       = 1'b0;
      pop        = 1'b0;
      err_set    = 1'b0;
      halt_set   = 1'b0;
      unique case (state)
         ST_RUN: begin
            unique case (f.opcode)
               OP_NOP: ;
               OP_JMP: begin
                  pc_mux_sel = 1'b1;
                  jmp_loc    = f.imm;
               end
               OP_BZ: begin
                  if (zero_flag) begin
                     pc_mux_sel = 1'b1;
                     jmp_loc    = f.imm;
                  end
               end
               OP_CALL: begin
                  pc_mux_sel = 1'b1;
                  jmp_loc    = f.imm;
                  push       = 1'b1;
                  err_set    = ras_full;
               end
               OP_RET: begin
                  pc_mux_sel = 1'b1;
                  if (ras_empty) begin
                     err_set = 1'b1;
                  end else begin
                     jmp_loc = ras_top;
                     pop     = 1'b1;
                  end
               end
               OP_MUL: begin
                  if (MUL_CYCLES > 1) begin
                     state_d = ST_HOLD;
                     cnt_d   = CNT_INIT;
                     stall_d = 1'b1;
                  end
               end
               OP_HALT: begin
                  state_d  = ST_HALT;
                  stall_d  = 1'b1;
                  halt_set = 1'b1;
               end
               default: ;
            endcase
         end
         ST_HOLD: begin
            if (cnt == '0) begin
               stall_d = 1'b0;
               state_d = ST_RUN;
            end else begin
               cnt_d = cnt - 1'b1;
            end
         end
         ST_HALT: ;
         default: state_d = ST_RUN;
      endcase
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state      <= ST_RUN;
         cnt        <= '0;
         stall      <= 1'b0;
         stall_pm   <= 1'b0;
         ins_pc     <= '0;
         dec_valid  <= 1'b0;
         dec_opcode <= '0;
         dec_rd     <= '0;
         dec_rs1    <= '0;
         dec_imm    <= '0;
         dec_pc     <= '0;
         halted     <= 1'b0;
         ras_err    <= 1'b0;
      end else begin
         state     <= state_d;
         cnt       <= cnt_d;
         stall     <= stall_d;
         stall_pm  <= stall_d;
         // while memory is held, ins keeps showing the same instruction
         if (!stall_d) ins_pc <= current_address;
         dec_valid <= (state == ST_RUN);
         if (state == ST_RUN) begin
            dec_opcode <= f.opcode;
            dec_rd     <= f.rd;
            dec_rs1    <= f.rs1;
            dec_imm    <= f.imm;
            dec_pc     <= ins_pc;
         end
         if (halt_set) halted  <= 1'b1;
         if (err_set)  ras_err <= 1'b1;
      end
   end

endmodule
